// File: rtl/pb_pkg.sv
// Shared types and constants for the DRAM arbiter slice.
// DRAM_ARB_ROUND_ROBIN_EN (in rr_arbiter/dram_arbiter) selects round-robin vs fixed priority.
package pb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } arb_state_t;

   localparam logic DRAM_RD = 1'b1;
   localparam logic DRAM_WR = 1'b0;

   localparam int REQ_FETCH = 0;
   localparam int REQ_WB    = 1;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational two-way grant select.
// DRAM_ARB_ROUND_ROBIN_EN defined: ties go to the requester not granted last; else fetch wins ties.
module rr_arbiter
   import pb_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last_gnt,
   output logic       gnt_id
);

`ifdef DRAM_ARB_ROUND_ROBIN_EN
   always_comb begin
      gnt_id = 1'(REQ_FETCH);
      if (&req)
         gnt_id = ~last_gnt;
      else if (req[REQ_WB])
         gnt_id = 1'(REQ_WB);
   end
`else
   logic unused_last_gnt;
   assign unused_last_gnt = last_gnt;

   always_comb begin
      gnt_id = 1'(REQ_FETCH);
      if (req[REQ_WB] && !req[REQ_FETCH])
         gnt_id = 1'(REQ_WB);
   end
`endif

endmodule

// File: rtl/dram_arbiter.sv
// Two-requester DRAM port arbiter with one transaction in flight and a timeout guard.
// DRAM_ARB_ROUND_ROBIN_EN builds the last_gnt register for round-robin tie breaking.
module dram_arbiter
   import pb_pkg::*;
#(
   parameter int NUM_REQ        = 2,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_REQ-1:0]       req,
   input  logic [NUM_REQ-1:0]       req_rdwr,
   input  logic [NUM_REQ-1:0][63:0] req_addr,
   input  logic [NUM_REQ-1:0][63:0] req_wdata,
   output logic [NUM_REQ-1:0]       done,
   output logic [63:0]              rdata,
   output logic [NUM_REQ-1:0]       err,
   output logic                     dram_en,
   output logic                     dram_rdwr,
   output logic [63:0]              dram_addr,
   output logic [63:0]              dram_data_in,
   input  logic [63:0]              dram_data_out,
   input  logic                     dram_valid
);

   localparam logic [6:0] TMO_LAST = 7'(TIMEOUT_CYCLES - 1);

   arb_state_t state, state_nxt;
   logic       gnt_id, arb_gnt, last_gnt;
   logic [6:0] tmo_cnt;
   logic       grant, complete, timeout;

   rr_arbiter u_arb (
      .req      (req[1:0]),
      .last_gnt (last_gnt),
      .gnt_id   (arb_gnt)
   );

   always_ff @(posedge clk) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      grant     = 1'b0;
      complete  = 1'b0;
      timeout   = 1'b0;
      case (state)
         IDLE: if (|req) begin
            grant     = 1'b1;
            state_nxt = BUSY;
         end
         BUSY: if (dram_valid) begin
            complete  = 1'b1;
            state_nxt = RESP;
         end else if (tmo_cnt == TMO_LAST) begin
            timeout   = 1'b1;
            state_nxt = RESP;
         end
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         gnt_id       <= 1'b0;
         dram_en      <= 1'b0;
         dram_rdwr    <= 1'b0;
         dram_addr    <= '0;
         dram_data_in <= '0;
         rdata        <= '0;
         done         <= '0;
         err          <= '0;
         tmo_cnt      <= '0;
      end else begin
         done <= '0;
         err  <= '0;
         if (grant) begin
            gnt_id       <= arb_gnt;
            dram_en      <= 1'b1;
            dram_rdwr    <= req_rdwr[arb_gnt];
            dram_addr    <= req_addr[arb_gnt];
            dram_data_in <= req_wdata[arb_gnt];
            tmo_cnt      <= '0;
         end
         if (state == BUSY && tmo_cnt != 7'h7f)
            tmo_cnt <= tmo_cnt + 7'd1;
         // rdata is loaded on writes too; a timeout forces it to zero
         if (complete || timeout) begin
            dram_en      <= 1'b0;
            done[gnt_id] <= 1'b1;
            err[gnt_id]  <= timeout;
            rdata        <= complete ? dram_data_out : 64'd0;
         end
      end
   end

`ifdef DRAM_ARB_ROUND_ROBIN_EN
   // Reset value favours fetch on the first tie.
   always_ff @(posedge clk) begin
      if (!reset)     last_gnt <= 1'(REQ_WB);
      else if (grant) last_gnt <= arb_gnt;
   end
`else
   assign last_gnt = 1'b0;
`endif

endmodule

// File: tb/tb_dram_arbiter.sv
// Directed bench for dram_arbiter with a DRAM responder model and a completion scoreboard.
module tb_dram_arbiter;
   import pb_pkg::*;

   localparam int TMO = 8;
   localparam logic [63:0] K = 64'h0000_0009_4018_0048;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic [1:0]       req = '0;
   logic [1:0]       req_rdwr = '0;
   logic [1:0][63:0] req_addr = '0;
   logic [1:0][63:0] req_wdata = '0;
   logic [1:0]       done;
   logic [63:0]      rdata;
   logic [1:0]       err;
   logic             dram_en, dram_rdwr;
   logic [63:0]      dram_addr, dram_data_in;
   logic [63:0]      dram_data_out = '0;
   logic             dram_valid = 1'b0;

   typedef struct {
      int          id;
      logic        err;
      logic [63:0] rdata;
   } exp_t;

   exp_t        sb[$];
   int          tests = 0;
   int          fails = 0;
   int          dram_lat = 2;
   int          en_cnt = 0;
   int          last_en_len = 0;
   bit          force_valid = 0;
   logic [63:0] last_rdata = '0;

   dram_arbiter #(.NUM_REQ(2), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .reset(reset), .req(req), .req_rdwr(req_rdwr),
      .req_addr(req_addr), .req_wdata(req_wdata), .done(done), .rdata(rdata),
      .err(err), .dram_en(dram_en), .dram_rdwr(dram_rdwr), .dram_addr(dram_addr),
      .dram_data_in(dram_data_in), .dram_data_out(dram_data_out), .dram_valid(dram_valid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // DRAM model: responds dram_lat cycles into a transaction (0 = never), data derived from address
   always @(negedge clk) begin
      dram_valid = 1'b0;
      if (dram_en) begin
         en_cnt++;
         if (dram_lat > 0 && en_cnt == dram_lat) begin
            dram_valid    = 1'b1;
            dram_data_out = dram_addr ^ K;
         end
      end else begin
         if (en_cnt > 0) last_en_len = en_cnt;
         en_cnt = 0;
      end
      if (force_valid) begin
         dram_valid    = 1'b1;
         dram_data_out = 64'hBAD0_BAD0_BAD0_BAD0;
         force_valid   = 0;
      end
   end

   // Completion monitor against the scoreboard
   always @(negedge clk) begin
      if (reset && (|done || |err)) begin
         if (sb.size() == 0) begin
            chk("unexpected_done", 64'(done), 64'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("done_id", 64'(done), 64'(2'b01 << e.id));
            chk("err", 64'(err), e.err ? 64'(2'b01 << e.id) : 64'd0);
            chk("rdata", rdata, e.rdata);
         end
      end
   end

   task automatic cyc();
      @(negedge clk);
      #1;
   endtask

   task automatic txn(input int id, input logic rw, input logic [63:0] a, input logic [63:0] wd,
                      input logic exp_err, input int exp_len);
      int n;
      exp_t e;
      e.id = id; e.err = exp_err; e.rdata = exp_err ? 64'd0 : (a ^ K);
      sb.push_back(e);
      last_rdata   = e.rdata;
      req_rdwr[id] = rw; req_addr[id] = a; req_wdata[id] = wd; req[id] = 1'b1;
      cyc();
      chk("en_rise", 64'(dram_en), 64'd1);
      n = 0;
      while (!done[id] && n < 200) begin
         if (dram_en) begin
            chk("dram_addr", dram_addr, a);
            chk("dram_data_in", dram_data_in, wd);
            chk("dram_rdwr", 64'(dram_rdwr), 64'(rw));
         end
         cyc();
         n++;
      end
      chk("done_timely", 64'(n < 200), 64'd1);
      req[id] = 1'b0;
      cyc();
      chk("en_len", 64'(last_en_len), 64'(exp_len));
      chk("en_low_after", 64'(dram_en), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n, got;
      exp_t e;
      cyc(); cyc();
      chk("rst_en", 64'(dram_en), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_err", 64'(err), 64'd0);
      chk("rst_rdata", rdata, 64'd0);
      chk("rst_addr", dram_addr, 64'd0);
      reset = 1'b1;
      cyc();

      // single read, write, timeout, then a normal request
      txn(REQ_FETCH, DRAM_RD, 64'h40, 64'h0, 1'b0, 2);
      chk("read_data", rdata, 64'h0000_0009_4018_0008);
      txn(REQ_WB, DRAM_WR, 64'h80, 64'hDEAD_BEEF, 1'b0, 2);
      dram_lat = 0;
      txn(REQ_FETCH, DRAM_RD, 64'h1000, 64'h0, 1'b1, TMO);
      chk("tmo_rdata", rdata, 64'd0);
      dram_lat = 3;
      txn(REQ_WB, DRAM_RD, 64'h2000, 64'h0, 1'b0, 3);

      // reset while BUSY: abandon without done
      dram_lat = 0;
      req_addr[0] = 64'h3000; req_rdwr[0] = DRAM_RD; req[0] = 1'b1;
      cyc(); cyc();
      chk("busy_en", 64'(dram_en), 64'd1);
      reset = 1'b0;
      cyc();
      chk("midrst_en", 64'(dram_en), 64'd0);
      chk("midrst_done", 64'(done), 64'd0);
      req[0] = 1'b0;
      reset = 1'b1;
      cyc(); cyc();
      chk("midrst_done2", 64'(done), 64'd0);

      // tie: both requesting for four transactions
      dram_lat = 1;
      req_addr[0] = 64'h100; req_rdwr[0] = DRAM_RD;
      req_addr[1] = 64'h200; req_rdwr[1] = DRAM_RD;
      for (int i = 0; i < 4; i++) begin
`ifdef DRAM_ARB_ROUND_ROBIN_EN
         e.id = i % 2;
`else
         e.id = 0;
`endif
         e.err = 1'b0;
         e.rdata = (e.id == 0 ? 64'h100 : 64'h200) ^ K;
         sb.push_back(e);
      end
      req = 2'b11;
      got = 0; n = 0;
      while (got < 4 && n < 100) begin
         cyc();
         n++;
         if (|done) got++;
      end
      req = 2'b00;
      last_rdata = e.rdata;
      chk("tie_count", 64'(got), 64'd4);
      cyc(); cyc();

      // spurious valid while idle
      force_valid = 1;
      cyc(); cyc(); cyc();
      chk("spur_done", 64'(done), 64'd0);
      chk("spur_rdata", rdata, last_rdata);
      chk("spur_en", 64'(dram_en), 64'd0);

      // post-reset request still completes normally
      dram_lat = 2;
      txn(REQ_FETCH, DRAM_RD, 64'h40, 64'h0, 1'b0, 2);

      chk("sb_empty", 64'(sb.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
